// File: rtl/relogio_pkg.sv
// relogio_pkg: shared types and constants for the clock controller.
// Mode encoding, HEX digit-pair positions and blink mask helpers.
package relogio_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } modo_t;

    // Low HEX index of each two-digit field
    localparam int HEX_HOUR_LO = 4;
    localparam int HEX_MIN_LO  = 2;
    localparam int HEX_SEC_LO  = 0;

    function automatic modo_t next_modo(modo_t m);
        modo_t n;
        n = RUN;
        unique case (m)
            RUN:      n = SET_HOUR;
            SET_HOUR: n = SET_MIN;
            SET_MIN:  n = SET_SEC;
            SET_SEC:  n = RUN;
            default:  n = RUN;
        endcase
        return n;
    endfunction

    function automatic logic [5:0] blink_mask(
        modo_t m,
        logic  ph
    );
        logic [5:0] mk;
        mk = '0;
        unique case (m)
            SET_HOUR: mk[HEX_HOUR_LO +: 2] = {2{ph}};
            SET_MIN:  mk[HEX_MIN_LO  +: 2] = {2{ph}};
            SET_SEC:  mk[HEX_SEC_LO  +: 2] = {2{ph}};
            default:  mk = '0;
        endcase
        return mk;
    endfunction

endpackage

// File: rtl/relogio_controle_if.sv
// relogio_controle_if: buttons in, strobes/mode/mask out.
// master drives the buttons; slave is the controller.
interface relogio_controle_if;

    logic       btn_mode;
    logic       btn_inc;
    logic       tick_1hz;
    logic       inc_hour;
    logic       inc_min;
    logic       inc_sec;
    logic [1:0] mode;
    logic [5:0] blank_mask;

    modport master (
        output btn_mode,
        output btn_inc,
        input  tick_1hz,
        input  inc_hour,
        input  inc_min,
        input  inc_sec,
        input  mode,
        input  blank_mask
    );

    modport slave (
        input  btn_mode,
        input  btn_inc,
        output tick_1hz,
        output inc_hour,
        output inc_min,
        output inc_sec,
        output mode,
        output blank_mask
    );

endinterface

// File: rtl/relogio_controle_divisor_tick.sv
// divisor_tick: modulo-N counter with enable and synchronous clear.
// wrap is high in the cycle the enabled count sits at N-1.
module divisor_tick #(
    parameter int N = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, then wrap, then increment
    always_comb begin
        wrap  = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/relogio_controle.sv
// relogio_controle: mode FSM, 1 Hz prescaler, set-mode increment
// strobes with auto-repeat, and blink mask for the HEX displays.
module relogio_controle
    import relogio_pkg::*;
#(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int BLINK_DIV     = 12_500_000,
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000
) (
    input logic               CLOCK_50,
    input logic               reset,
    relogio_controle_if.slave bus
);

    modo_t      mode_q, mode_d;
    logic       mode_prev_q, mode_prev_d;
    logic       inc_prev_q, inc_prev_d;
    logic       armed_q, armed_d;
    logic       rpt_q, rpt_d;
    logic       phase_q, phase_d;
    logic       tick_q, tick_d;
    logic       inc_hour_q, inc_hour_d;
    logic       inc_min_q, inc_min_d;
    logic       inc_sec_q, inc_sec_d;
    logic [5:0] mask_q, mask_d;

    logic mode_rise;
    logic inc_rise;
    logic in_set;
    logic accept;
    logic hold_on;
    logic blink_en;
    logic hold_en;
    logic rpt_en;
    logic strobe;
    logic pre_wrap;
    logic blink_wrap;
    logic hold_wrap;
    logic rpt_wrap;

    // Button edges and repeat qualifiers; mode beats inc
    always_comb begin
        mode_rise = bus.btn_mode & ~mode_prev_q;
        inc_rise  = bus.btn_inc & ~inc_prev_q;
        in_set    = (mode_q != RUN);
        accept    = in_set & inc_rise & ~mode_rise;
        hold_on   = armed_q & bus.btn_inc & ~mode_rise;
        blink_en  = in_set & ~mode_rise;
        hold_en   = hold_on & ~rpt_q;
        rpt_en    = hold_on & rpt_q;
    end

    divisor_tick #(.N(CLK_FREQ)) u_pre (
        .clk  (CLOCK_50),
        .rst  (reset),
        .en   (~in_set),
        .clr  (in_set),
        .wrap (pre_wrap)
    );

    divisor_tick #(.N(BLINK_DIV)) u_blink (
        .clk  (CLOCK_50),
        .rst  (reset),
        .en   (blink_en),
        .clr  (~blink_en),
        .wrap (blink_wrap)
    );

    divisor_tick #(.N(HOLD_CYCLES)) u_hold (
        .clk  (CLOCK_50),
        .rst  (reset),
        .en   (hold_en),
        .clr  (~hold_en),
        .wrap (hold_wrap)
    );

    divisor_tick #(.N(REPEAT_CYCLES)) u_rpt (
        .clk  (CLOCK_50),
        .rst  (reset),
        .en   (rpt_en),
        .clr  (~rpt_en),
        .wrap (rpt_wrap)
    );

    // Next mode, repeat arming, blink phase and registered outputs
    always_comb begin
        mode_d      = mode_q;
        armed_d     = 1'b0;
        rpt_d       = 1'b0;
        phase_d     = 1'b0;
        strobe      = 1'b0;
        tick_d      = 1'b0;
        inc_hour_d  = 1'b0;
        inc_min_d   = 1'b0;
        inc_sec_d   = 1'b0;
        mode_prev_d = bus.btn_mode;
        inc_prev_d  = bus.btn_inc;
        if (mode_rise) begin
            mode_d = next_modo(mode_q);
        end
        armed_d    = accept | hold_on;
        rpt_d      = hold_on & (rpt_q | hold_wrap);
        phase_d    = blink_en & (phase_q ^ blink_wrap);
        strobe     = accept | hold_wrap | rpt_wrap;
        tick_d     = pre_wrap;
        inc_hour_d = strobe & (mode_q == SET_HOUR);
        inc_min_d  = strobe & (mode_q == SET_MIN);
        inc_sec_d  = strobe & (mode_q == SET_SEC);
        mask_d     = blink_mask(mode_d, phase_d);
    end

    // Button history follows the inputs even in reset, so a button
    // held across reset release does not register as a press
    always_ff @(posedge CLOCK_50) begin
        mode_prev_q <= mode_prev_d;
        inc_prev_q  <= inc_prev_d;
    end

    // State and output registers
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            mode_q     <= RUN;
            armed_q    <= 1'b0;
            rpt_q      <= 1'b0;
            phase_q    <= 1'b0;
            tick_q     <= 1'b0;
            inc_hour_q <= 1'b0;
            inc_min_q  <= 1'b0;
            inc_sec_q  <= 1'b0;
            mask_q     <= '0;
        end else begin
            mode_q     <= mode_d;
            armed_q    <= armed_d;
            rpt_q      <= rpt_d;
            phase_q    <= phase_d;
            tick_q     <= tick_d;
            inc_hour_q <= inc_hour_d;
            inc_min_q  <= inc_min_d;
            inc_sec_q  <= inc_sec_d;
            mask_q     <= mask_d;
        end
    end

    assign bus.tick_1hz   = tick_q;
    assign bus.inc_hour   = inc_hour_q;
    assign bus.inc_min    = inc_min_q;
    assign bus.inc_sec    = inc_sec_q;
    assign bus.mode       = mode_q;
    assign bus.blank_mask = mask_q;

endmodule
